// File: rtl/ps2_keycode_decoder_fifo_if.sv
// Key-event stream from the decoder FIFO head to its consumer (valid/ready).
interface ps2_keycode_decoder_fifo_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_keycode;
  logic       ev_ext;
  logic       ev_make;

  modport master (output ev_valid, ev_keycode, ev_ext, ev_make, input ev_ready);
  modport slave  (input ev_valid, ev_keycode, ev_ext, ev_make, output ev_ready);
endinterface

// File: rtl/ps2_keycode_decoder_fifo.sv
// PS/2 scan-code set 2 decoder feeding a first-word-fall-through event FIFO.
// Optional typematic repeat suppression: define REPEAT_FILTER_EN.
module ps2_keycode_decoder_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ps2_key_en,
  input  logic [7:0]                  ps2_key_data,
  ps2_keycode_decoder_fifo_if.master  ev,
  output logic [CNT_W-1:0]            fifo_count,
  output logic                        overflow,
  output logic                        seq_abort
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_F0, S_E0, S_E0F0, S_E1} state_t;

  state_t          state, state_nx, state_eff;
  logic [2:0]      e1_cnt, e1_cnt_nx;
  logic [TO_W-1:0] to_cnt, to_cnt_nx;
  logic            timeout_hit;
  logic            abort_nx;
  logic            push_req, push_fire;
  logic [7:0]      push_code;
  logic            push_ext, push_make;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state != S_IDLE) && (to_cnt == TO_LAST);

  // A timeout and a byte on the same cycle: abort first, then decode the byte from idle.
  always_comb begin
    state_eff = timeout_hit ? S_IDLE : state;
    state_nx  = state_eff;
    e1_cnt_nx = e1_cnt;
    abort_nx  = timeout_hit;
    push_req  = 1'b0;
    push_code = ps2_key_data;
    push_ext  = 1'b0;
    push_make = 1'b1;
    if (ps2_key_en) begin
      case (state_eff)
        S_IDLE: begin
          case (ps2_key_data)
            8'hE0: state_nx = S_E0;
            8'hF0: state_nx = S_F0;
            8'hE1: begin
              state_nx  = S_E1;
              e1_cnt_nx = '0;
            end
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_nx = S_IDLE;
            default: push_req = 1'b1;
          endcase
        end
        S_F0: begin
          state_nx = S_IDLE;
          if (ps2_key_data inside {8'hE0, 8'hE1, 8'hF0}) begin
            abort_nx = 1'b1;
          end else begin
            push_req  = 1'b1;
            push_make = 1'b0;
          end
        end
        S_E0: begin
          state_nx = S_IDLE;
          if (ps2_key_data == 8'hF0) begin
            state_nx = S_E0F0;
          end else if (ps2_key_data inside {8'hE0, 8'hE1}) begin
            abort_nx = 1'b1;
          end else begin
            push_req = 1'b1;
            push_ext = 1'b1;
          end
        end
        S_E0F0: begin
          state_nx = S_IDLE;
          if (ps2_key_data inside {8'hE0, 8'hE1, 8'hF0}) begin
            abort_nx = 1'b1;
          end else begin
            push_req  = 1'b1;
            push_ext  = 1'b1;
            push_make = 1'b0;
          end
        end
        S_E1: begin
          if (e1_cnt == 3'd6) begin
            state_nx  = S_IDLE;
            push_req  = 1'b1;
            push_code = 8'hE1;
            push_ext  = 1'b1;
          end else begin
            e1_cnt_nx = e1_cnt + 3'd1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    if ((TIMEOUT_CYCLES == 0) || ps2_key_en || timeout_hit || (state == S_IDLE))
      to_cnt_nx = '0;
    else
      to_cnt_nx = to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      e1_cnt <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_nx;
      e1_cnt <= e1_cnt_nx;
      to_cnt <= to_cnt_nx;
    end
  end

`ifdef REPEAT_FILTER_EN
  logic       held_valid, held_ext;
  logic [7:0] held_code;
  logic       held_match, is_pause;

  // Pause is the only event that can carry {ext=1, E1}.
  assign is_pause   = push_ext && (push_code == 8'hE1);
  assign held_match = held_valid && (held_ext == push_ext) && (held_code == push_code);
  assign push_fire  = push_req && !(push_make && !is_pause && held_match);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= '0;
    end else if (push_req && !is_pause) begin
      if (push_make) begin
        held_valid <= 1'b1;
        held_ext   <= push_ext;
        held_code  <= push_code;
      end else if (held_match) begin
        held_valid <= 1'b0;
      end
    end
  end
`else
  assign push_fire = push_req;
`endif

  logic [9:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop, wr_en, ovf_nx;
  logic [9:0]       head;

  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign pop    = ev.ev_valid && ev.ev_ready;
  assign wr_en  = push_fire && (!full || pop);
  assign ovf_nx = push_fire && full && !pop;
  assign head   = mem[rd_ptr];

  assign ev.ev_valid   = (count != '0);
  assign ev.ev_keycode = ev.ev_valid ? head[9:2] : '0;
  assign ev.ev_ext     = ev.ev_valid && head[1];
  assign ev.ev_make    = ev.ev_valid && head[0];
  assign fifo_count    = count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {push_code, push_ext, push_make};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      seq_abort <= 1'b0;
    end else begin
      overflow  <= ovf_nx;
      seq_abort <= abort_nx;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keycode_decoder_fifo.sv
// Scoreboard bench: a byte-sequence reference model predicts the event stream and pulses.
module tb_ps2_keycode_decoder_fifo;
  localparam int DEPTH = 4;
  localparam int TO    = 20;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [7:0]    data = '0;
  logic [CW-1:0] fifo_count;
  logic          overflow, seq_abort;
  int            ready_mode = 1;

  ps2_keycode_decoder_fifo_if evif ();

  ps2_keycode_decoder_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .reset_n(reset_n), .ps2_key_en(en), .ps2_key_data(data),
    .ev(evif), .fifo_count(fifo_count), .overflow(overflow), .seq_abort(seq_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] code; logic ext; logic make;} ev_t;

  ev_t        exp_q[$];
  logic [7:0] pend[$];
  int         idle = 0;
  logic       exp_ovf = 1'b0, exp_abort = 1'b0;
  ev_t        cls_ev;
  int         n_vec = 0, n_miss = 0, cyc = 0;
  logic       held_valid = 1'b0;
  ev_t        held;

  localparam int INC = 0, EVT = 1, ERR = 2, DROP = 3;

  function automatic logic is_pfx(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);
  endfunction

  // Interprets the bytes collected since the last completed sequence.
  function int classify();
    int n;
    n = pend.size();
    if (pend[0] == 8'hE1) begin
      cls_ev = '{8'hE1, 1'b1, 1'b1};
      return (n == 8) ? EVT : INC;
    end
    if (pend[0] == 8'hE0) begin
      if (n == 1) return INC;
      if (pend[1] == 8'hF0) begin
        if (n == 2) return INC;
        cls_ev = '{pend[2], 1'b1, 1'b0};
        return is_pfx(pend[2]) ? ERR : EVT;
      end
      cls_ev = '{pend[1], 1'b1, 1'b1};
      return (pend[1] == 8'hE0 || pend[1] == 8'hE1) ? ERR : EVT;
    end
    if (pend[0] == 8'hF0) begin
      if (n == 1) return INC;
      cls_ev = '{pend[1], 1'b0, 1'b0};
      return is_pfx(pend[1]) ? ERR : EVT;
    end
    if (pend[0] inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) return DROP;
    cls_ev = '{pend[0], 1'b0, 1'b1};
    return EVT;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete(); pend.delete();
      idle = 0; exp_ovf = 1'b0; exp_abort = 1'b0; held_valid = 1'b0;
    end else begin
      logic have, pop, drop;
      int   r;
      have = 1'b0;
      exp_abort = 1'b0;
      pop = evif.ev_ready && (exp_q.size() > 0);
      if (pend.size() > 0 && idle + 1 == TO) begin
        exp_abort = 1'b1;
        pend.delete();
        idle = 0;
      end
      if (en) begin
        idle = 0;
        pend.push_back(data);
        r = classify();
        if (r != INC) pend.delete();
        if (r == ERR) exp_abort = 1'b1;
        if (r == EVT) have = 1'b1;
      end else if (pend.size() > 0) begin
        idle++;
      end
`ifdef REPEAT_FILTER_EN
      if (have && !(cls_ev.ext && cls_ev.code == 8'hE1)) begin
        if (cls_ev.make) begin
          if (held_valid && held.code == cls_ev.code && held.ext == cls_ev.ext) have = 1'b0;
          held_valid = 1'b1;
          held = cls_ev;
        end else if (held_valid && held.code == cls_ev.code && held.ext == cls_ev.ext) begin
          held_valid = 1'b0;
        end
      end
`endif
      drop = have && (exp_q.size() == DEPTH) && !pop;
      exp_ovf = drop;
      if (pop) void'(exp_q.pop_front());
      if (have && !drop) exp_q.push_back(cls_ev);
    end
  end

  always @(negedge clk) begin
    logic ev_exp;
    ev_t  h;
    cyc++;
    n_vec++;
    ev_exp = exp_q.size() > 0;
    h = ev_exp ? exp_q[0] : '0;
    if (evif.ev_valid !== ev_exp || fifo_count !== CW'(exp_q.size()) ||
        overflow !== exp_ovf || seq_abort !== exp_abort ||
        (ev_exp && (evif.ev_keycode !== h.code || evif.ev_ext !== h.ext ||
                    evif.ev_make !== h.make))) begin
      n_miss++;
      $display("FAIL cycle %0d event/flags: got valid=%b code=%h ext=%b make=%b cnt=%0d ovf=%b abort=%b, want valid=%b code=%h ext=%b make=%b cnt=%0d ovf=%b abort=%b",
               cyc, evif.ev_valid, evif.ev_keycode, evif.ev_ext, evif.ev_make, fifo_count,
               overflow, seq_abort, ev_exp, h.code, h.ext, h.make, exp_q.size(), exp_ovf, exp_abort);
    end
  end

  initial begin
    evif.ev_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       evif.ev_ready = 1'b0;
        1:       evif.ev_ready = 1'b1;
        default: evif.ev_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    en = 1'b1;
    data = b;
    @(negedge clk);
    en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    logic [7:0] resp [6];
    logic [7:0] fill [5];
    logic [7:0] rep [6];
    logic       abort_seen;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    resp      = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    fill      = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D};
    rep       = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};

    idle_cycles(3);
    if (evif.ev_valid !== 1'b0 || evif.ev_keycode !== 8'h00 || evif.ev_ext !== 1'b0 ||
        evif.ev_make !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0 ||
        seq_abort !== 1'b0) begin
      n_miss++;
      $display("FAIL reset state: valid=%b code=%h ext=%b make=%b cnt=%0d ovf=%b abort=%b",
               evif.ev_valid, evif.ev_keycode, evif.ev_ext, evif.ev_make, fifo_count,
               overflow, seq_abort);
    end
    reset_n = 1'b1;
    idle_cycles(2);

    send(8'h1C, 2); send(8'hF0, 0); send(8'h1C, 3);
    send(8'hE0, 0); send(8'h75, 1); send(8'hFA, 1); send(8'hAA, 1);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 3);

    ready_mode = 0;
    idle_cycles(1);
    foreach (pause_seq[i]) send(pause_seq[i], 0);
    idle_cycles(3);
    ready_mode = 1;
    idle_cycles(3);

    send(8'hE0, 0);
    abort_seen = 1'b0;
    for (int unsigned k = 0; k < TO + 2; k++) begin
      @(negedge clk);
      if (seq_abort === 1'b1) abort_seen = 1'b1;
    end
    if (!abort_seen) begin
      n_miss++;
      $display("FAIL timeout: no seq_abort pulse within %0d cycles of a stalled E0", TO + 2);
    end
    send(8'h1C, 3);
    send(8'hF0, TO - 2);
    send(8'h1C, 3);

    ready_mode = 0;
    idle_cycles(2);
    foreach (fill[i]) send(fill[i], 1);
    ready_mode = 1;
    idle_cycles(1);
    send(8'h2E, 0);
    idle_cycles(DEPTH + 3);

    foreach (rep[i]) send(rep[i], 1);
    idle_cycles(4);

    ready_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      int r, g;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 10)      b = 8'hE0;
      else if (r < 18) b = 8'hF0;
      else if (r < 21) b = 8'hE1;
      else if (r < 27) b = resp[$urandom_range(0, 5)];
      else             b = 8'($urandom_range(0, 255));
      g = ($urandom_range(0, 49) == 0) ? TO + $urandom_range(0, 2) - 1 : $urandom_range(0, 3);
      send(b, g);
    end

    ready_mode = 1;
    idle_cycles(TO + 10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ps2_keycode_decoder_fifo.md
Name: ps2_keycode_decoder_fifo

Overview:
Next-generation PS/2 scan-code set 2 decoder. It sits after the PS/2 byte receiver and turns byte streams into key events: make/break, E0-extended and the 8-byte E1 Pause sequence. Completed events go into a parametrised first-word-fall-through FIFO with a valid/ready handshake. A timeout aborts stalled partial sequences, and controller response bytes are filtered out.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
TIMEOUT_CYCLES, 1000000, idle clocks allowed inside a partial sequence before abort; 0 disables the timeout.
CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
ps2_key_en  in  1  one-cycle strobe; ps2_key_data is valid.
ps2_key_data  in  8  received PS/2 byte.
ev_valid  out  1  FIFO not empty; head event present on ev_keycode/ev_ext/ev_make.
ev_ready  in  1  consumer accepts the head event when ev_valid && ev_ready.
ev_keycode  out  8  head event scan code (8'hE1 for Pause).
ev_ext  out  1  head event is E0/E1-extended.
ev_make  out  1  1 = press, 0 = release.
fifo_count  out  CNT_W  number of entries currently stored.
overflow  out  1  one-cycle pulse when a completed event is dropped because the FIFO is full.
seq_abort  out  1  one-cycle pulse when a partial sequence is discarded (timeout or protocol error).

Behaviour:
- Reset (async assert, sync release). State goes to S_IDLE and the FIFO empties. ev_valid, ev_keycode, ev_ext, ev_make, fifo_count, overflow and seq_abort are all 0. The timeout counter and the E1 byte counter are 0.
- Bytes are accepted only on cycles where ps2_key_en=1.
- States: S_IDLE, S_F0, S_E0, S_E0F0, S_E1.
- S_IDLE:
  - E0 -> S_E0.
  - F0 -> S_F0.
  - E1 -> S_E1 with e1_cnt=0.
  - FA, AA, EE, FE, 00, FF are controller responses: dropped, state stays S_IDLE.
  - Any other byte XX: push {XX, ext=0, make=1} and stay in S_IDLE.
- S_F0:
  - E0, E1 or F0: seq_abort pulse -> S_IDLE, nothing pushed.
  - Other XX: push {XX, 0, 0} -> S_IDLE.
- S_E0:
  - F0 -> S_E0F0.
  - E0 or E1: seq_abort -> S_IDLE.
  - Other XX: push {XX, 1, 1} -> S_IDLE.
- S_E0F0:
  - E0, E1 or F0: seq_abort -> S_IDLE.
  - Other XX: push {XX, 1, 0} -> S_IDLE.
- S_E1:
  - Each byte increments e1_cnt; byte contents are not checked.
  - On the 7th byte: push {E1, 1, 1} -> S_IDLE. No break event is generated for Pause.
- Latency: an event is written on the edge that accepts its final byte. ev_valid and fifo_count reflect it on the next cycle. No extra decode cycle.
- Timeout:
  - The counter is cleared on every accepted byte and whenever state is S_IDLE.
  - It increments each cycle while state is not S_IDLE.
  - When it reaches TIMEOUT_CYCLES: seq_abort pulse, state -> S_IDLE, counter cleared.
  - If a byte arrives on the same cycle the timeout fires, the abort wins and the byte is reprocessed as if received in S_IDLE.
- FIFO:
  - First-word fall-through: ev_* show the head entry whenever ev_valid=1 and hold it until popped.
  - Pop occurs when ev_valid && ev_ready.
  - Push while full with no pop: event dropped, overflow pulse, contents unchanged.
  - Push and pop in the same cycle: both succeed, count unchanged. This holds when full (no overflow) and at count=1.
  - Push while empty: ev_valid rises the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - ev_ready while empty has no effect.
- seq_abort and overflow can pulse in the same cycle.

Optional Feature:
REPEAT_FILTER_EN
- When defined:
  - A held-key register {valid, ext, keycode} suppresses typematic repeats.
  - A make event whose ext/keycode equal the held key is not pushed. It causes no overflow.
  - Any other non-Pause make is pushed and becomes the held key.
  - A break whose ext/keycode equal the held key clears valid. Every break is still pushed.
  - Pause bypasses the filter.
  - The held-key register is cleared by reset.
- When not defined: every make is pushed and there is no held-key logic.

Test Plan:
- 1C, then F0 1C, ev_ready=1 -> events {1C,0,1} and {1C,0,0}; each ev_valid appears 1 cycle after its final byte.
- E0 75, then E0 F0 75 -> {75,1,1}, {75,1,0}. FA and AA injected between them produce no event.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,1,1}; fifo_count=1.
- TIMEOUT_CYCLES=20, send E0 then idle 20 cycles -> seq_abort pulse, state S_IDLE. Following 1C -> {1C,0,1}, not extended.
- FIFO_DEPTH=4, ev_ready=0, 5 make codes:
  - 5th make: overflow pulse, fifo_count=4.
  - Push with ev_ready=1 while full: no overflow, count stays 4.
  - Drain: order preserved.
- REPEAT_FILTER_EN defined, 1C 1C 1C F0 1C 1C -> pushed events {1C,make}, {1C,break}, {1C,make}. Undefined -> 5 events.
